// File: rtl/d_reg_pipe_if.sv
// ---------------------------------------------------------------------------
// d_reg_pipe_if
//   Bundles the data-path and status signals of the d_reg_pipe delay line so
//   producers and consumers connect through a single port.
//
//   Parameters
//     WIDTH   data width in bits
//     DEPTH   number of pipeline stages; sets the width of count
//
//   Signals
//     en          advance enable (0 = stall)
//     flush       synchronous clear of all stages
//     d           input data word
//     d_valid     qualifies d
//     q           output data word (last stage)
//     q_valid     valid bit of the last stage
//     count       number of stages currently holding valid data
//     parity_err  last-stage parity mismatch; present only when
//                 D_REG_PIPE_PARITY_EN is defined
//
//   Modports
//     master  drives en/flush/d/d_valid and observes the outputs
//     slave   the pipeline itself
// ---------------------------------------------------------------------------
interface d_reg_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [CW-1:0]    count;
`ifdef D_REG_PIPE_PARITY_EN
    logic             parity_err;
`endif

`ifdef D_REG_PIPE_PARITY_EN
    modport master (
        output en, flush, d, d_valid,
        input  q, q_valid, count, parity_err
    );

    modport slave (
        input  en, flush, d, d_valid,
        output q, q_valid, count, parity_err
    );
`else
    modport master (
        output en, flush, d, d_valid,
        input  q, q_valid, count
    );

    modport slave (
        input  en, flush, d, d_valid,
        output q, q_valid, count
    );
`endif

endinterface

// File: rtl/d_reg_pipe.sv
// ---------------------------------------------------------------------------
// d_reg_pipe
//   Parametrised D-register delay line. A WIDTH-bit word enters stage 0 on
//   every enabled clock edge and moves one stage further per enabled edge,
//   appearing on q after DEPTH enabled edges. Each stage carries a valid bit
//   so bubbles keep their slots, and a registered counter tracks how many
//   stages hold valid data. With DEPTH=1 and en=1, flush=0, d_valid=1 the
//   block is a plain D flip-flop with reset.
//
//   Optional feature macro: D_REG_PIPE_PARITY_EN
//     When defined, each stage also stores the even parity of its data word
//     and parity_err flags a mismatch on the valid last stage.
//
//   Parameters
//     WIDTH    data width in bits (>= 1)
//     DEPTH    number of stages = latency in enabled cycles (>= 1)
//     RST_VAL  data value loaded into every stage on reset and flush
//
//   Ports
//     clk     clock, rising edge
//     reset   synchronous, active-low reset (0 = reset)
//     bus     d_reg_pipe_if.slave: en, flush, d, d_valid in;
//             q, q_valid, count (and parity_err) out
//
//   Edge priority: reset > flush > en > hold. All outputs come straight from
//   registers, so there is no combinational path from inputs to outputs.
// ---------------------------------------------------------------------------
module d_reg_pipe #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    d_reg_pipe_if.slave   bus
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next;

    // Reset and flush perform the same clear; only the cause differs.
    logic clear;
    assign clear = !reset || bus.flush;

    // Data and valid shift register. Stage 0 loads the input, every other
    // stage takes its predecessor; the old last stage simply falls off.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_data[i]  <= RST_VAL;
                stage_valid[i] <= 1'b0;
            end
        end else if (bus.en) begin
            stage_data[0]  <= bus.d;
            stage_valid[0] <= bus.d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage_data[i]  <= stage_data[i-1];
                stage_valid[i] <= stage_valid[i-1];
            end
        end
    end

    // Occupancy moves by at most one per edge: +1 when a valid word enters
    // and the leaving word is a bubble, -1 for the reverse, unchanged when
    // both or neither happen. This keeps count in 0..DEPTH without wrapping.
    always_comb begin
        count_next = count_r;
        if (bus.d_valid && !stage_valid[DEPTH-1]) begin
            count_next = count_r + CW'(1);
        end else if (!bus.d_valid && stage_valid[DEPTH-1]) begin
            count_next = count_r - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= '0;
        end else if (bus.en) begin
            count_r <= count_next;
        end
    end

    assign bus.q       = stage_data[DEPTH-1];
    assign bus.q_valid = stage_valid[DEPTH-1];
    assign bus.count   = count_r;

`ifdef D_REG_PIPE_PARITY_EN
    // Parity travels alongside its word; a cleared stage holds the parity
    // of RST_VAL so an invalid stage is always self-consistent.
    logic stage_par [DEPTH];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_par[i] <= ^RST_VAL;
            end
        end else if (bus.en) begin
            stage_par[0] <= ^bus.d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_par[i] <= stage_par[i-1];
            end
        end
    end

    // Only a valid output word can raise an error; decoded from registers.
    assign bus.parity_err = stage_valid[DEPTH-1] &&
                            ((^stage_data[DEPTH-1]) != stage_par[DEPTH-1]);
`endif

endmodule
